// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter.
//   state_e      : transmitter FSM states (PARITY only exists when
//                  UART_TX_PARITY_EN is defined)
//   LINE_IDLE    : level of the serial line when nothing is being sent
//   START_BIT    : level of the start bit
//   PARITY_BITS  : 1 when the parity bit is built in, else 0
//   frame_cycles : clock cycles from START entry to IDLE entry
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after DATA).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_cycles(int clk_div, int word_size, int stop_bits);
    return (1 + word_size + PARITY_BITS + stop_bits) * clk_div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer.
//   clk_i        : clock, rising edge
//   rst_n_i      : async active-low reset
//   sync_clear_i : hold the count at zero (restart the bit period)
//   tick_o       : one-cycle pulse in the last cycle of every p_clk_div
//                  cycle bit period
module uart_baud_tick #(
  parameter int p_clk_div = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sync_clear_i,
  output logic tick_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == 16'(p_clk_div - 1));
    cnt_d  = tick_o ? '0 : cnt_q + 16'd1;
    if (sync_clear_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART transmitter, LSB first, 1 or 2 stop bits.
//   clk_i        : clock, rising edge
//   rst_n_i      : async active-low reset
//   fifo_data_i  : head word of the upstream FIFO
//   fifo_valid_i : upstream FIFO not empty
//   fifo_read_o  : one-cycle pop strobe (only in IDLE)
//   tx_o         : serial line, idle high, registered
//   busy_o       : high whenever a frame is in progress
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int p_clk_div   = 16,
  parameter int p_word_size = 7,
  parameter int p_stop_bits = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [p_word_size-1:0] fifo_data_i,
  input  logic                   fifo_valid_i,
  output logic                   fifo_read_o,
  output logic                   tx_o,
  output logic                   busy_o
);

  localparam int IDX_W = 3;

  state_e                 state_q, state_d;
  logic [p_word_size-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   tx_q, tx_d;
  logic                   tick, pop;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  // Timer is held cleared in IDLE so START always gets a full period.
  uart_baud_tick #(.p_clk_div(p_clk_div)) u_baud (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .sync_clear_i (state_q == ST_IDLE),
    .tick_o       (tick)
  );

  // tx_d is computed for the state being entered, so the registered line
  // already carries the new bit in the first cycle of that state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = LINE_IDLE;
        if (fifo_valid_i) begin
          pop     = 1'b1;
          shift_d = fifo_data_i;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_data_i;
`endif
          state_d = ST_START;
          tx_d    = START_BIT;
        end
      end
      ST_START: if (tick) begin
        state_d = ST_DATA;
        idx_d   = '0;
        tx_d    = shift_q[0];
      end
      ST_DATA: if (tick) begin
        if (idx_q == IDX_W'(p_word_size - 1)) begin
          idx_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
          tx_d    = par_q;
`else
          state_d = ST_STOP;
          tx_d    = LINE_IDLE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (tick) begin
        state_d = ST_STOP;
        idx_d   = '0;
        tx_d    = LINE_IDLE;
      end
`endif
      ST_STOP: if (tick) begin
        tx_d = LINE_IDLE;
        if (idx_q == IDX_W'(p_stop_bits - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Gate with reset so the strobe drops the moment reset asserts.
  assign fifo_read_o = pop & rst_n_i;
  assign tx_o        = tx_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + randomized bench for uart_tx. Two instances:
// u0 (4 clocks/bit, 7 data bits, 1 stop) and u1 (3 clocks/bit, 8 data
// bits, 2 stop). Expected line waveforms come from a frame model built
// as a plain list of bit levels.
module tb_uart_tx;

  localparam int DIV0 = 4, WS0 = 7, SB0 = 1;
  localparam int DIV1 = 3, WS1 = 8, SB1 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [WS0-1:0] d0 = '0;
  logic [WS1-1:0] d1 = '0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic rd0, tx0, bz0, rd1, tx1, bz1;

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  logic rd_s, tx_s, bz_s;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.p_clk_div(DIV0), .p_word_size(WS0), .p_stop_bits(SB0)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_data_i(d0), .fifo_valid_i(v0),
    .fifo_read_o(rd0), .tx_o(tx0), .busy_o(bz0));

  uart_tx #(.p_clk_div(DIV1), .p_word_size(WS1), .p_stop_bits(SB1)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_data_i(d1), .fifo_valid_i(v1),
    .fifo_read_o(rd1), .tx_o(tx1), .busy_o(bz1));

  always_comb begin
    rd_s = (sel == 0) ? rd0 : rd1;
    tx_s = (sel == 0) ? tx0 : tx1;
    bz_s = (sel == 0) ? bz0 : bz1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [7:0] d);
    if (sel == 0) begin v0 = v; d0 = d[WS0-1:0]; end
    else          begin v1 = v; d1 = d[WS1-1:0]; end
  endtask

  // Frame model: start, data LSB first, optional even parity, stop bits,
  // each level held for one bit period.
  task automatic build_exp(input logic [7:0] w);
    int div, ws, sb;
    bit p;
    div = (sel == 0) ? DIV0 : DIV1;
    ws  = (sel == 0) ? WS0  : WS1;
    sb  = (sel == 0) ? SB0  : SB1;
    exp_q.delete();
    p = 1'b0;
    for (int c = 0; c < div; c++) exp_q.push_back(1'b0);
    for (int b = 0; b < ws; b++) begin
      p ^= w[b];
      for (int c = 0; c < div; c++) exp_q.push_back(w[b]);
    end
    if (PAR == 1)
      for (int c = 0; c < div; c++) exp_q.push_back(p);
    for (int c = 0; c < sb * div; c++) exp_q.push_back(1'b1);
  endtask

  // Called at the negedge of the first START cycle; returns at the negedge
  // of the first IDLE cycle after the frame.
  task automatic mon_frame(input string tag, input bit scramble);
    int errs, pops, nbusy;
    errs = 0; pops = 0; nbusy = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (scramble) set_in(1'($urandom), 8'($urandom));
      #1;
      if (tx_s !== exp_q[i]) errs++;
      if (rd_s !== 1'b0) pops++;
      if (bz_s !== 1'b1) nbusy++;
      @(negedge clk);
    end
    chk({tag, "_bits"}, errs, 0);
    chk({tag, "_nopop"}, pops, 0);
    chk({tag, "_busy"}, nbusy, 0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] w, input bit scramble);
    build_exp(w);
    set_in(1'b1, w);
    #1;
    chk({tag, "_pop"}, rd_s, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 8'($urandom));
    mon_frame(tag, scramble);
    set_in(1'b0, 8'h00);
    #1;
    chk({tag, "_idle_tx"}, tx_s, 1'b1);
    chk({tag, "_idle_busy"}, bz_s, 1'b0);
    chk({tag, "_idle_rd"}, rd_s, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    int bad_tx, pops;

    // Reset state, with valid high to confirm no pop while in reset.
    v0 = 1'b1; v1 = 1'b1; d0 = 7'h2A; d1 = 8'hC3;
    repeat (3) @(negedge clk);
    sel = 0; #1;
    chk("rst0_tx", tx_s, 1'b1); chk("rst0_busy", bz_s, 1'b0); chk("rst0_rd", rd_s, 1'b0);
    sel = 1; #1;
    chk("rst1_tx", tx_s, 1'b1); chk("rst1_busy", bz_s, 1'b0); chk("rst1_rd", rd_s, 1'b0);
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sel = 0; #1;
    chk("idle_hold_tx", tx_s, 1'b1);
    chk("idle_hold_rd", rd_s, 1'b0);
    @(negedge clk);

    // Single word 0x55.
    sel = 0;
    run_frame("w55", 8'h55, 1'b0);

    // Back-to-back: 0x01 then 0x7F with valid held; next pop lands in the
    // single IDLE cycle right after the first frame.
    build_exp(8'h01);
    set_in(1'b1, 8'h01);
    #1; chk("b2b_pop1", rd_s, 1'b1);
    @(posedge clk); @(negedge clk);
    set_in(1'b1, 8'h7F);
    mon_frame("b2b_f1", 1'b0);
    #1;
    chk("b2b_pop2", rd_s, 1'b1);
    chk("b2b_gap_tx", tx_s, 1'b1);
    chk("b2b_gap_busy", bz_s, 1'b0);
    build_exp(8'h7F);
    @(posedge clk); @(negedge clk);
    set_in(1'b0, 8'h00);
    mon_frame("b2b_f2", 1'b0);
    #1; chk("b2b_end_busy", bz_s, 1'b0);
    @(negedge clk);

    // Parity-sensitive words (odd and even popcount).
    run_frame("w07", 8'h07, 1'b0);
    run_frame("w03", 8'h03, 1'b0);

    // Random words, alternating with random input noise during the frame.
    for (int k = 0; k < 6; k++) begin
      w = 8'($urandom);
      run_frame($sformatf("rnd%0d", k), w, k[0]);
    end

    // Two stop bits, 8-bit words on the second instance.
    sel = 1;
    run_frame("s2_a5", 8'hA5, 1'b0);
    run_frame("s2_ff", 8'hFF, 1'b1);
    run_frame("s2_rnd", 8'($urandom), 1'b1);

    // Reset in the middle of data bit 3 of 0x55 (bit 3 is 0).
    sel = 0;
    set_in(1'b1, 8'h55);
    #1; chk("rstmid_pop", rd_s, 1'b1);
    @(posedge clk); @(negedge clk);
    set_in(1'b0, 8'h00);
    repeat (DIV0 * 4 + 1) @(negedge clk);
    #1;
    chk("rstmid_bit3", tx_s, 1'b0);
    chk("rstmid_busy_pre", bz_s, 1'b1);
    set_in(1'b1, 8'h12);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx", tx_s, 1'b1);
    chk("rstmid_busy", bz_s, 1'b0);
    chk("rstmid_rd", rd_s, 1'b0);
    set_in(1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bad_tx = 0; pops = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (tx_s !== 1'b1) bad_tx++;
      if (rd_s !== 1'b0) pops++;
      @(negedge clk);
    end
    chk("postrst_tx", bad_tx, 0);
    chk("postrst_nopop", pops, 0);

    // Normal traffic resumes after the aborted frame.
    run_frame("postrst", 8'h3C, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter p_clk_div, default 16: clock cycles per serial bit, legal range 2..65535.
REQ-002 The module SHALL have parameter p_word_size, default 7: data bits per frame, legal range 5..8.
REQ-003 The module SHALL have parameter p_stop_bits, default 1: stop bits per frame, legal values 1 or 2.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The module SHALL have port fifo_data_i, input, p_word_size bits: the word at the head of the upstream FIFO, combinationally valid while fifo_valid_i=1.
REQ-007 The module SHALL have port fifo_valid_i, input, 1 bit: the upstream FIFO is not empty.
REQ-008 The module SHALL have port fifo_read_o, output, 1 bit: a one-cycle pop strobe to the FIFO read enable.
REQ-009 The module SHALL have port tx_o, output, 1 bit: the serial line, idle high.
REQ-010 The module SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The module SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-012 In IDLE with fifo_valid_i=1, the module SHALL assert fifo_read_o for exactly that cycle, latch fifo_data_i into a shift register in the same cycle, and enter START on the next edge.
REQ-013 The module SHALL assert fifo_read_o only in IDLE and only when fifo_valid_i=1; there SHALL be no pop while busy.
REQ-014 Each of START, each DATA bit, PARITY and each STOP bit SHALL drive tx_o for exactly p_clk_div cycles, timed by a bit counter that reloads on every bit boundary.
REQ-015 START SHALL drive tx_o=0.
REQ-016 DATA SHALL send p_word_size bits LSB first, counted by a bit index from 0 to p_word_size-1.
REQ-017 STOP SHALL drive tx_o=1 for p_stop_bits bit periods, then enter IDLE.
REQ-018 A full frame SHALL occupy (1+p_word_size+P+p_stop_bits)*p_clk_div cycles from START entry to IDLE entry, where P=1 with parity and P=0 without.
REQ-019 With fifo_valid_i continuously high, consecutive frames SHALL be separated by exactly one IDLE cycle, with tx_o=1 during that cycle.
REQ-020 In IDLE with fifo_valid_i=0, tx_o SHALL remain 1 indefinitely.
REQ-021 Changes on fifo_valid_i or fifo_data_i during a frame SHALL NOT affect the frame in progress.
REQ-022 tx_o SHALL be driven from a flop so that it is glitch-free.

Reset
REQ-023 Asserting rst_n_i SHALL immediately set tx_o=1, fifo_read_o=0, busy_o=0, state=IDLE, and clear the counters and the shift register.
REQ-024 A reset asserted mid-frame SHALL abandon the frame; the abandoned word is lost and SHALL NOT be re-popped.
REQ-025 After rst_n_i deasserts, the first pop SHALL occur no earlier than the first rising edge on which rst_n_i=1 and fifo_valid_i=1.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, PARITY SHALL be inserted after DATA for one bit period, driving the even-parity bit (the XOR of the data bits).
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum typedef, the line idle level and start-bit level constants, and a function computing frame length.
REQ-029 The bit-period counter SHALL be a sub-module uart_baud_tick that outputs a one-cycle tick every p_clk_div cycles and restarts on a sync_clear input.

Verification
REQ-030 With p_clk_div=4, p_word_size=7, 1 stop bit, no parity, and a single word 7'h55: fifo_read_o pulses once; tx_o then reads 0,1,0,1,0,1,0,1,1, each for 4 cycles; busy_o falls 36 cycles after START entry.
REQ-031 With fifo_valid_i held high and words 7'h01 then 7'h7F: two frames result, separated by exactly one high IDLE cycle, with two pops exactly 37 cycles apart.
REQ-032 With parity enabled and word 7'h07: the PARITY bit is 1; with word 7'h03 the PARITY bit is 0; each frame is 40 cycles long.
REQ-033 With p_stop_bits=2: tx_o is high for 8 cycles after the last data bit before IDLE.
REQ-034 Asserting rst_n_i during DATA bit 3: tx_o goes to 1 without waiting for a clock edge and busy_o goes to 0; after release, with fifo_valid_i=0, there is no pop and tx_o stays 1.
REQ-035 Toggling fifo_valid_i and fifo_data_i randomly mid-frame: the frame content is unchanged and fifo_read_o stays 0 until IDLE.
